// File: rtl/des_round_controller.sv
// Iterative DES round sequencer: IP/PC-1 at load, 16 rounds through an external
// f-function (one per clock), C/D key schedule for either direction, FP on output.
module des_round_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in_block,
    input  logic [1:64] in_key,
    input  logic        in_decrypt,
    output logic [1:32] round_r,
    output logic [1:56] round_cd,
    input  logic [1:32] f_result,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_block
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [6:0] IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam logic [6:0] FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam logic [6:0] PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    state_t      state_q;
    logic [1:32] l_q, r_q;
    logic [1:56] cd_q;
    logic [3:0]  cnt_q;
    logic        mode_q;
    logic        in_ready_q, busy_q, out_valid_q;
    logic [1:64] out_block_q;

    logic [1:64] ip_w, fp_w, preout_w;
    logic [1:56] pc1_w, cd_d;
    logic [1:0]  amt_w;

    assign preout_w = {l_q ^ f_result, r_q};

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_perm64
            assign ip_w[gi+1] = in_block[IP_T[gi]];
            assign fp_w[gi+1] = preout_w[FP_T[gi]];
        end
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_w[gi+1] = in_key[PC1_T[gi]];
        end
    endgenerate

    // Rounds 1, 2, 9 and 16 shift by one, all others by two.
    function automatic logic [1:0] shift_of(input logic [4:0] i);
        return (i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[2:28], x[1]};
            2'd2:    return {x[3:28], x[1:2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[28], x[1:27]};
            2'd2:    return {x[27:28], x[1:26]};
            default: return x;
        endcase
    endfunction

    // Decrypt walks the encrypt schedule backwards, starting from the unrotated key.
    always_comb begin
        amt_w = 2'd0;
        cd_d  = cd_q;
        if (!mode_q) begin
            amt_w = shift_of({1'b0, cnt_q} + 5'd1);
            cd_d  = {rotl28(cd_q[1:28], amt_w), rotl28(cd_q[29:56], amt_w)};
        end else begin
            amt_w = (cnt_q == 4'd0) ? 2'd0 : shift_of(5'd17 - {1'b0, cnt_q});
            cd_d  = {rotr28(cd_q[1:28], amt_w), rotr28(cd_q[29:56], amt_w)};
        end
    end

    assign round_r   = (state_q == ROUND) ? r_q   : '0;
    assign round_cd  = (state_q == ROUND) ? cd_d  : '0;
    assign round_idx = (state_q == ROUND) ? cnt_q : 4'd0;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_block = out_block_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            cd_q        <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_block_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        {l_q, r_q} <= ip_w;
                        cd_q       <= pc1_w;
                        mode_q     <= in_decrypt;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    cd_q  <= cd_d;
                    l_q   <= r_q;
                    r_q   <= l_q ^ f_result;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // Output is FP(R16 || L16): the last swap is undone here.
                        out_block_q <= fp_w;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_block_q <= '0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
